bcd2hex: RTL

- Sequential BCD-to-binary converter; the inverse of the display-path BCD conversion.
- Takes an 8-digit packed BCD time word (preset entered via keys/encoder) and produces the binary field values used to preload the stopwatch counters.
- Sits between key/preset entry logic and the counters block.
- Uses an iterative reverse double-dabble algorithm (shift right, then subtract 3 from any BCD nibble >= 8), with a start/busy/done handshake.

---
 rtl/bcd2hex_pkg.sv | 36 +++
 rtl/bcd2hex_lane.sv | 19 +
 rtl/bcd2hex.sv | 107 ++++++++++
 3 files changed

// File: rtl/bcd2hex_pkg.sv
// Shared constants and types for the packed-BCD time word to binary converter.
package bcd2hex_pkg;

    localparam int TV_W = 7;
    localparam int MV_W = 6;
    localparam int SV_W = 6;
    localparam int HV_W = 7;

    localparam int TV_LSB = 24;
    localparam int MV_LSB = 16;
    localparam int SV_LSB = 8;
    localparam int HV_LSB = 0;

    localparam int MAX_MS = 59;
    localparam int MAX_TH = 99;

    // Highest legal tens digit of a minute/second field.
    localparam logic [3:0] MS_TENS_MAX = 4'(MAX_MS / 10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_LOAD
    } state_e;

    function automatic logic all_decimal(input logic [31:0] word);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (word[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd2hex_lane.sv
// One reverse double-dabble step for a 2-digit field: shift {bcd,bin} right, then
// subtract 3 from every BCD nibble that landed at 8 or above.
module bcd2bin_lane (
    input  logic [7:0] bcd,
    input  logic [7:0] bin,
    output logic [7:0] bcd_next,
    output logic [7:0] bin_next
);

    logic [7:0] shifted;

    always_comb begin
        shifted  = {1'b0, bcd[7:1]};
        bin_next = {bcd[0], bin[7:1]};
        bcd_next[7:4] = (shifted[7:4] >= 4'd8) ? shifted[7:4] - 4'd3 : shifted[7:4];
        bcd_next[3:0] = (shifted[3:0] >= 4'd8) ? shifted[3:0] - 4'd3 : shifted[3:0];
    end

endmodule

// File: rtl/bcd2hex.sv
// Iterative BCD-to-binary converter for the tv:mv:sv:hv preset word; four fields
// are converted in parallel behind a start/busy/done/err handshake.
module bcd2hex
    import bcd2hex_pkg::*;
#(
    parameter bit CHECK_RANGE = 1'b1,
    parameter int N_ITER      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     bcd8d,
    output logic [TV_W-1:0] tv,
    output logic [MV_W-1:0] mv,
    output logic [SV_W-1:0] sv,
    output logic [HV_W-1:0] hv,
    output logic            busy,
    output logic            done,
    output logic            err,
    output state_e          state
);

    logic [31:0] work;
    logic [31:0] acc;
    logic [31:0] work_next;
    logic [31:0] acc_next;
    logic [3:0]  iter;
    logic        in_ok;
    logic        range_ok;

    for (genvar f = 0; f < 4; f++) begin : g_lane
        bcd2bin_lane u_lane (
            .bcd      (work[8*f +: 8]),
            .bin      (acc[8*f +: 8]),
            .bcd_next (work_next[8*f +: 8]),
            .bin_next (acc_next[8*f +: 8])
        );
    end

    assign range_ok = !CHECK_RANGE ||
                      ((work[MV_LSB+4 +: 4] <= MS_TENS_MAX) &&
                       (work[SV_LSB+4 +: 4] <= MS_TENS_MAX));
    assign in_ok = all_decimal(work) && range_ok;

    // Bits above each field width are always zero for checked inputs.
    logic unused_hi;
    assign unused_hi = ^{acc_next[31], acc_next[23:22], acc_next[15:14], acc_next[7]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            work  <= '0;
            acc   <= '0;
            iter  <= '0;
            tv    <= '0;
            mv    <= '0;
            sv    <= '0;
            hv    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // LOAD doubles as an idle cycle so conversions can run back to back.
                ST_IDLE, ST_LOAD: begin
                    if (start) begin
                        work  <= bcd8d;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= ST_CHECK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (!in_ok) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        iter  <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    acc  <= acc_next;
                    iter <= iter + 4'd1;
                    // Results are registered on entry so they are valid while done is high.
                    if (iter == 4'(N_ITER - 1)) begin
                        tv    <= acc_next[TV_LSB +: TV_W];
                        mv    <= acc_next[MV_LSB +: MV_W];
                        sv    <= acc_next[SV_LSB +: SV_W];
                        hv    <= acc_next[HV_LSB +: HV_W];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
